// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter.
// State codes are 8 bits wide to line up with the transmitter's own state register.
package uart_pkg;

    typedef enum logic [7:0] {
        ST_IDLE      = 8'd0,
        ST_LAUNCH    = 8'd1,
        ST_WAIT_BUSY = 8'd2,
        ST_WAIT_DONE = 8'd3,
        ST_GAP       = 8'd4
    } state_t;

    localparam int UART_FRAME_BITS = 10;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker.
// Searches from last+1 upward, modulo N_REQ.
module rr_pick #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0] i_req_valid,
    input  logic [2:0]       i_last,
    output logic             o_found,
    output logic [2:0]       o_idx
);

    logic [7:0] w_vld8;
    int         c;

    assign w_vld8 = 8'(i_req_valid);

    // Walk from the farthest candidate back, so the nearest one wins.
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        c       = 0;
        for (int k = N_REQ; k >= 1; k--) begin
            c = int'(i_last) + k;
            if (c >= N_REQ) c = c - N_REQ;
            if (w_vld8[3'(c)]) begin
                o_found = 1'b1;
                o_idx   = 3'(c);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one 8N1 transmitter between N_REQ producers.
// Tracks each frame via tx_done, enforces an idle gap, flags stuck transmitters.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int GAP_CYCLES = 2,
    parameter int TIMEOUT    = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [8*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]   req_ready,
    output logic [7:0]         tx_byte,
    output logic               tx_send,
    input  logic               tx_done,
    output logic               busy,
    output logic [2:0]         grant_idx,
    output logic               err_timeout
);

    state_t      r_state;
    state_t      w_next;
    logic [2:0]  r_last;
    logic [7:0]  r_tx_byte;
    logic [2:0]  r_grant;
    logic        r_err;
    logic [7:0]  r_gap_cnt;
    logic [15:0] r_to_cnt;

    logic        w_found;
    logic [2:0]  w_idx;
    logic        w_grant;
    logic        w_timeout;
    logic        w_to_hit;
    logic        w_gap_hit;
    logic [7:0]  w_sel_data;

    rr_pick #(.N_REQ(N_REQ)) u_pick (
        .i_req_valid (req_valid),
        .i_last      (r_last),
        .o_found     (w_found),
        .o_idx       (w_idx)
    );

    assign w_grant   = (r_state == ST_IDLE) && w_found && tx_done && !rst;
    assign w_to_hit  = r_to_cnt >= 16'(TIMEOUT - 1);
    assign w_gap_hit = int'(r_gap_cnt) >= GAP_CYCLES - 1;

    always_comb begin
        w_sel_data = '0;
        req_ready  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (w_idx == 3'(k)) begin
                w_sel_data   = req_data[8*k +: 8];
                req_ready[k] = w_grant;
            end
        end
    end

    always_comb begin
        w_next    = r_state;
        w_timeout = 1'b0;
        case (r_state)
            ST_IDLE:      if (w_grant) w_next = ST_LAUNCH;
            ST_LAUNCH:    w_next = ST_WAIT_BUSY;
            ST_WAIT_BUSY: begin
                if (!tx_done) begin
                    w_next = ST_WAIT_DONE;
                end else if (w_to_hit) begin
                    w_next    = ST_IDLE;
                    w_timeout = 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                if (tx_done) begin
                    w_next = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
                end else if (w_to_hit) begin
                    w_next    = ST_IDLE;
                    w_timeout = 1'b1;
                end
            end
            ST_GAP:       if (w_gap_hit) w_next = ST_IDLE;
            default:      w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_last    <= 3'(N_REQ - 1);
            r_tx_byte <= '0;
            r_grant   <= '0;
            r_err     <= 1'b0;
            r_gap_cnt <= '0;
            r_to_cnt  <= '0;
        end else begin
            r_state <= w_next;
            r_err   <= r_err | w_timeout;
            if (w_grant) begin
                r_tx_byte <= w_sel_data;
                r_grant   <= w_idx;
                r_last    <= w_idx;
            end
            // Counters clear whenever the state changes.
            if ((r_state == ST_WAIT_BUSY || r_state == ST_WAIT_DONE)
                && w_next == r_state) begin
                if (r_to_cnt != '1) r_to_cnt <= r_to_cnt + 16'd1;
            end else begin
                r_to_cnt <= '0;
            end
            if (r_state == ST_GAP && w_next == ST_GAP) begin
                if (r_gap_cnt != '1) r_gap_cnt <= r_gap_cnt + 8'd1;
            end else begin
                r_gap_cnt <= '0;
            end
        end
    end

    assign tx_byte     = r_tx_byte;
    assign tx_send     = (r_state == ST_LAUNCH);
    assign busy        = (r_state != ST_IDLE);
    assign grant_idx   = r_grant;
    assign err_timeout = r_err;

endmodule
